// File: rtl/mul_div_unit_pkg.sv
// Shared operation codes and op-class helpers for the multiply/divide unit.
// Imported by the datapath sub-module, the top level and the testbench.
package mul_div_unit_pkg;

    typedef enum logic [3:0] {
        MDOP_NONE  = 4'd0,
        MDOP_MULT  = 4'd1,
        MDOP_MULTU = 4'd2,
        MDOP_DIV   = 4'd3,
        MDOP_DIVU  = 4'd4,
        MDOP_MFHI  = 4'd5,
        MDOP_MFLO  = 4'd6,
        MDOP_MTHI  = 4'd7,
        MDOP_MTLO  = 4'd8,
        MDOP_MADD  = 4'd9,
        MDOP_MADDU = 4'd10,
        MDOP_MSUB  = 4'd11,
        MDOP_MSUBU = 4'd12
    } md_op_e;

    function automatic logic md_is_mult(input logic [3:0] op);
        return op inside {MDOP_MULT, MDOP_MULTU, MDOP_MADD, MDOP_MADDU,
                          MDOP_MSUB, MDOP_MSUBU};
    endfunction

    function automatic logic md_is_div(input logic [3:0] op);
        return op inside {MDOP_DIV, MDOP_DIVU};
    endfunction

endpackage

// File: rtl/mul_div_unit_arith.sv
// Combinational multiply/divide datapath: latched operands and current HI/LO in,
// next HI/LO and a write enable out (write enable drops for a zero divisor).
module mdu_arith
    import mul_div_unit_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [3:0]   i_op,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic [W-1:0] i_hi,
    input  logic [W-1:0] i_lo,
    output logic [W-1:0] o_hi_nxt,
    output logic [W-1:0] o_lo_nxt,
    output logic         o_we
);

    logic [2*W-1:0] w_prod_s;
    logic [2*W-1:0] w_prod_u;
    logic [2*W-1:0] w_acc;
    logic [2*W-1:0] w_res;

    // Explicit extension keeps both products exact modulo 2^(2W).
    assign w_prod_s = {{W{i_a[W-1]}}, i_a} * {{W{i_b[W-1]}}, i_b};
    assign w_prod_u = {{W{1'b0}}, i_a} * {{W{1'b0}}, i_b};
    assign w_acc    = {i_hi, i_lo};

    // Signed divide runs on magnitudes; -2^(W-1) / -1 wraps naturally this way.
    logic         w_signed;
    logic         w_a_neg;
    logic         w_b_neg;
    logic         w_b_zero;
    logic [W-1:0] w_dvd;
    logic [W-1:0] w_dvs;
    logic [W-1:0] w_quo_mag;
    logic [W-1:0] w_rem_mag;
    logic [W-1:0] w_quo;
    logic [W-1:0] w_rem;

    assign w_signed  = (i_op == MDOP_DIV);
    assign w_a_neg   = w_signed & i_a[W-1];
    assign w_b_neg   = w_signed & i_b[W-1];
    assign w_b_zero  = (i_b == '0);
    assign w_dvd     = w_a_neg ? (~i_a + W'(1)) : i_a;
    assign w_dvs     = w_b_zero ? W'(1) : (w_b_neg ? (~i_b + W'(1)) : i_b);
    assign w_quo_mag = w_dvd / w_dvs;
    assign w_rem_mag = w_dvd % w_dvs;
    assign w_quo     = (w_a_neg ^ w_b_neg) ? (~w_quo_mag + W'(1)) : w_quo_mag;
    assign w_rem     = w_a_neg ? (~w_rem_mag + W'(1)) : w_rem_mag;

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        w_res = w_acc;
        o_we  = 1'b0;
        case (i_op)
            MDOP_MULT:  begin w_res = w_prod_s;         o_we = 1'b1; end
            MDOP_MULTU: begin w_res = w_prod_u;         o_we = 1'b1; end
            MDOP_MADD:  begin w_res = w_acc + w_prod_s; o_we = 1'b1; end
            MDOP_MADDU: begin w_res = w_acc + w_prod_u; o_we = 1'b1; end
            MDOP_MSUB:  begin w_res = w_acc - w_prod_s; o_we = 1'b1; end
            MDOP_MSUBU: begin w_res = w_acc - w_prod_u; o_we = 1'b1; end
            MDOP_DIV, MDOP_DIVU: begin
                w_res = {w_rem, w_quo};
                o_we  = ~w_b_zero;
            end
            default: ;
        endcase
    end

    assign o_hi_nxt = w_res[2*W-1:W];
    assign o_lo_nxt = w_res[W-1:0];

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Holds the busy counter, latched operands, HI/LO and the accept logic.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int W           = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [3:0]   op,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         flush,
    output logic         busy,
    output logic [W-1:0] HI,
    output logic [W-1:0] LO,
    output logic [W-1:0] C
);

    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_op;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [W-1:0]     r_hi;
    logic [W-1:0]     r_lo;

    logic             w_accept;
    logic             w_commit;
    logic             w_we;
    logic [W-1:0]     w_hi_nxt;
    logic [W-1:0]     w_lo_nxt;

    assign busy     = (r_cnt != '0);
    assign w_accept = start & ~flush & ~busy;
    assign w_commit = (r_cnt == CNT_W'(1)) & w_we;

    mdu_arith #(.W(W)) u_arith (
        .i_op     (r_op),
        .i_a      (r_a),
        .i_b      (r_b),
        .i_hi     (r_hi),
        .i_lo     (r_lo),
        .o_hi_nxt (w_hi_nxt),
        .o_lo_nxt (w_lo_nxt),
        .o_we     (w_we)
    );

    // NOTE: sequential state uses non-blocking assignments only.
    // Accept and commit never coincide: accept requires the counter to be idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            r_op  <= MDOP_NONE;
            r_a   <= '0;
            r_b   <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
        end else begin
            if (busy)
                r_cnt <= r_cnt - CNT_W'(1);
            if (w_commit) begin
                r_hi <= w_hi_nxt;
                r_lo <= w_lo_nxt;
            end
            if (w_accept) begin
                if (md_is_mult(op) || md_is_div(op)) begin
                    r_cnt <= md_is_mult(op) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                    r_op  <= op;
                    r_a   <= A;
                    r_b   <= B;
                end else if (op == MDOP_MTHI) begin
                    r_hi <= A;
                end else if (op == MDOP_MTLO) begin
                    r_lo <= A;
                end
            end
        end
    end

    assign HI = r_hi;
    assign LO = r_lo;

    always_comb begin
        C = '0;
        if (op == MDOP_MFHI)
            C = r_hi;
        else if (op == MDOP_MFLO)
            C = r_lo;
    end

endmodule
